piso: RTL
=========

Name: piso

Overview:
- Parallel-in serial-out shift register: the transmit end of the serial adder datapath.
- Captures a WIDTH-bit operand on a load request and presents it on one serial line, LSB first, one bit per shift-enabled clock.
- It feeds the serial adder and the serial-in/parallel-out collector downstream.
- Reports bit-valid and a one-cycle completion pulse, and supports stalling via shift.

Parameters:
WIDTH, 4, operand width in bits (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  request to capture din; honoured only when idle
din  input  WIDTH  parallel operand
shift  input  1  advance-one-bit enable while busy
sout  output  1  serial data bit, LSB first
busy  output  1  high while a word is being serialised; sout valid when high
ready  output  1  high when idle and able to accept load (equals ~busy)
done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high.
- Reset (any time, including mid-word): sreg=0, cnt=0, busy=0, done=0. So sout=0 and ready=1 immediately, with no clock needed. An in-flight word is discarded with no done pulse.
- State registers:
  - sreg[WIDTH-1:0]
  - cnt, wide enough to hold WIDTH-1 (minimum 1 bit)
  - busy
  - done
- States:
  - IDLE (busy=0)
  - SHIFTING (busy=1)
- IDLE:
  - Rising edge with load=1: sreg<=din, cnt<=0, busy<=1 -> SHIFTING.
  - shift is ignored in IDLE.
  - load=0: registers hold; done<=0.
- SHIFTING:
  - shift=0: hold sreg/cnt. sout stays stable (stall) for any number of cycles.
  - shift=1 and cnt<WIDTH-1: sreg<=sreg>>1 (zero fill at MSB), cnt<=cnt+1.
  - shift=1 and cnt==WIDTH-1: busy<=0, done<=1, sreg<=0, cnt<=0 -> IDLE.
  - load is ignored while busy, including in the final-shift cycle. The next load is accepted no earlier than the following cycle, so the minimum word period is WIDTH+1 cycles.
- Outputs:
  - sout = busy ? sreg[0] : 0. This is combinational from registers, with no input-to-output path.
  - busy and done are registered.
  - done is high for exactly one cycle, the cycle after the final shift. It is cleared on every other cycle.
  - ready = ~busy.
- Latency:
  - Bit 0 of din appears on sout the cycle after load is accepted.
  - Bit k is shown after k accepted shifts.
  - With shift held high, a word occupies WIDTH cycles of busy, followed by done.
- WIDTH=1: the first shift while busy ends the word. No right shift occurs.
- din is sampled only on the accepting edge. Later changes to din have no effect.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> sout=0, busy=0, ready=1, done=0 immediately, before any clk edge.
2. WIDTH=4, din=4'b1011, load for 1 cycle, then shift held 1 -> sout=1,1,0,1 on consecutive cycles; busy high 4 cycles; done=1 on the 5th cycle only; then ready=1.
3. Stall: din=4'b0110, shift pattern 1,0,0,1,1,1 -> sout sequence 0,1,1,1,1,0 (held during the zeros); done only after the 4th accepted shift.
4. load=1 with din=4'b1111 asserted while busy, including the final-shift cycle -> ignored, current word completes unchanged. Held load is accepted the cycle after the final shift, and the new word starts with sout=1.
5. Reset asserted after 2 of 4 bits -> busy drops at once, no done pulse. A following load of 4'b1000 serialises as 0,0,0,1.
6. IDLE with shift=1 and load=0 for 5 cycles -> sout=0, busy=0, done never pulses.

Source files
------------

// File: rtl/piso_if.sv
// Handshake bundle between the operand source and the parallel-in serial-out shifter.
// The master drives load/din/shift; the slave (piso) returns the serial bit and status.
interface piso_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             shift;
    logic             sout;
    logic             busy;
    logic             ready;
    logic             done;

    modport master (
        output load, din, shift,
        input  sout, busy, ready, done
    );

    modport slave (
        input  load, din, shift,
        output sout, busy, ready, done
    );
endinterface

// File: rtl/piso.sv
// Parallel-in serial-out shifter: captures din when idle, emits it LSB first one bit per shift.
// sout valid the cycle after load; shift=0 stalls indefinitely; load ignored while busy; done pulses once.
module piso #(
    parameter int WIDTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    piso_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!busy_q) begin
            if (bus.load) begin
                sreg_d = bus.din;
                cnt_d  = '0;
                busy_d = 1'b1;
            end
        end else if (bus.shift) begin
            // The final shift retires the word instead of shifting, so WIDTH=1 never shifts.
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                sreg_d = '0;
                cnt_d  = '0;
            end else begin
                sreg_d = sreg_q >> 1;
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.sout  = busy_q ? sreg_q[0] : 1'b0;
    assign bus.busy  = busy_q;
    assign bus.ready = ~busy_q;
    assign bus.done  = done_q;
endmodule
